// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants and the pattern-to-BCD decode used by the
// display encoder and the loop-back scan decoder.
package seg7_pkg;

  // Active-low segments, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] bcd;
  } seg7_dec_t;

  typedef enum logic {S_WAIT, S_HELD} scan_state_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
    seg7_dec_t r;
    r = '0;
    if (pat == SEG_BLANK) begin
      r.legal    = 1'b1;
      r.is_blank = 1'b1;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (pat == SEG_DIGIT[i]) begin
          r.legal = 1'b1;
          r.bcd   = 4'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder: legal flag, blank flag and BCD value.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] bcd_o
);

  seg7_dec_t dec;

  always_comb begin
    dec     = seg7_decode(pat_i);
    legal_o = dec.legal;
    blank_o = dec.is_blank;
    bcd_o   = dec.bcd;
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor for the multiplexed 7-segment bus: synchronizes, filters for
// stability, decodes each stable pattern and keeps one BCD register per digit.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_N,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_N,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    err,
  output logic [7:0]              err_count
);

  localparam int          SW   = 7 + NUM_DIGITS;
  localparam logic [SW-1:0] IDLE = {SEG_BLANK, {NUM_DIGITS{1'b1}}};
  localparam logic [7:0]  STBL = 8'(STABLE_CYCLES);

  logic [SW-1:0] sync1_q, sync2_q, prev_q;
  logic [7:0]    cnt_q, cnt_d;
  scan_state_t   state_q, state_d;

  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [NUM_DIGITS-1:0]      blank_q, valid_q;
  logic                       update_q, err_q;
  logic [2:0]                 update_idx_q;
  logic [7:0]                 err_count_q;

  logic [6:0]            smp_seg;
  logic [NUM_DIGITS-1:0] smp_sel;
  logic                  changed, commit;
  logic [3:0]            n_low;
  logic [2:0]            sel_idx;
  logic                  dec_legal, dec_blank;
  logic [3:0]            dec_bcd;
  logic                  upd_d, err_d;

  assign smp_seg = sync2_q[SW-1 -: 7];
  assign smp_sel = sync2_q[NUM_DIGITS-1:0];

  seg7_pattern_decode u_dec (
    .pat_i   (smp_seg),
    .legal_o (dec_legal),
    .blank_o (dec_blank),
    .bcd_o   (dec_bcd)
  );

  // Stability filter: a change restarts the count; a commit fires once per
  // stable pattern, including straight from S_HELD when one sample suffices.
  always_comb begin
    changed = (sync2_q != prev_q);
    if (changed)              cnt_d = 8'd1;
    else if (cnt_q == 8'hFF)  cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;
    commit  = (changed || state_q == S_WAIT) && (cnt_d == STBL);
    if (commit)       state_d = S_HELD;
    else if (changed) state_d = S_WAIT;
    else              state_d = state_q;
  end

  always_comb begin
    n_low   = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!smp_sel[i]) begin
        n_low   = n_low + 4'd1;
        sel_idx = 3'(i);
      end
    end
    upd_d = commit && (n_low == 4'd1) && dec_legal;
    err_d = commit && ((n_low >= 4'd2) || ((n_low == 4'd1) && !dec_legal));
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync1_q      <= IDLE;
      sync2_q      <= IDLE;
      prev_q       <= IDLE;
      cnt_q        <= '0;
      state_q      <= S_WAIT;
      digits_q     <= '0;
      blank_q      <= '1;
      valid_q      <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      sync1_q  <= {seg_in, dig_sel_N};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      update_q <= upd_d;
      err_q    <= err_d;
      if (upd_d) begin
        update_idx_q     <= sel_idx;
        valid_q[sel_idx] <= 1'b1;
        blank_q[sel_idx] <= dec_blank;
        if (!dec_blank) digits_q[sel_idx] <= dec_bcd;
      end
      if (err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign digits     = digits_q;
  assign blank      = blank_q;
  assign valid      = valid_q;
  assign update     = update_q;
  assign update_idx = update_idx_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: vector table plus glitch, saturation and async reset sequences.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_N;
  logic [6:0]  seg_in;
  logic [5:0]  dig_sel_N;
  logic [23:0] digits;
  logic [5:0]  blank, valid;
  logic        update, err;
  logic [2:0]  update_idx;
  logic [7:0]  err_count;

  seg7_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_N(rst_N), .seg_in(seg_in), .dig_sel_N(dig_sel_N),
    .digits(digits), .blank(blank), .valid(valid), .update(update),
    .update_idx(update_idx), .err(err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [5:0]  sel;
    int          cyc;
    int          n_upd;
    int          n_err;
    int          first;
    logic [2:0]  idx;
    logic [23:0] dig;
    logic [5:0]  vld;
    logic [5:0]  blk;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [12];
  int   n_chk, n_fail;
  int   n_upd, n_err, first, both, tot_err;
  logic [2:0] idx_s;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a pattern for n cycles, recording pulses and when the first one occurs.
  task automatic hold(input logic [6:0] s, input logic [5:0] d, input int n);
    seg_in = s; dig_sel_N = d;
    n_upd = 0; n_err = 0; first = -1; both = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (update) begin
        n_upd++; idx_s = update_idx;
        if (first < 0) first = t;
      end
      if (err) begin
        n_err++;
        if (first < 0) first = t;
      end
      if (update && err) both++;
    end
  endtask

  task automatic check_regs(input string tag, input logic [23:0] dg, input logic [5:0] vl,
                            input logic [5:0] bl, input logic [7:0] ec);
    check({tag, ".digits"}, 32'(digits), 32'(dg));
    check({tag, ".valid"}, 32'(valid), 32'(vl));
    check({tag, ".blank"}, 32'(blank), 32'(bl));
    check({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; idx_s = '0;
    //          seg         sel        cyc upd err first idx  digits    valid  blank  ecnt
    vecs[0]  = '{7'h7F,      6'b111111, 20, 0, 0, -1, 3'd0, 24'h000000, 6'h00, 6'h3F, 8'd0};
    vecs[1]  = '{7'b0100100, 6'b111110, 10, 1, 0,  6, 3'd0, 24'h000002, 6'h01, 6'h3E, 8'd0};
    vecs[2]  = '{7'b1111001, 6'b111110,  8, 1, 0,  6, 3'd0, 24'h000001, 6'h01, 6'h3E, 8'd0};
    vecs[3]  = '{7'b0100100, 6'b111101,  8, 1, 0,  6, 3'd1, 24'h000021, 6'h03, 6'h3C, 8'd0};
    vecs[4]  = '{7'b0110000, 6'b111011,  8, 1, 0,  6, 3'd2, 24'h000321, 6'h07, 6'h38, 8'd0};
    vecs[5]  = '{7'b0011001, 6'b110111,  8, 1, 0,  6, 3'd3, 24'h004321, 6'h0F, 6'h30, 8'd0};
    vecs[6]  = '{7'b0010010, 6'b101111,  8, 1, 0,  6, 3'd4, 24'h054321, 6'h1F, 6'h20, 8'd0};
    vecs[7]  = '{7'b0000010, 6'b011111,  8, 1, 0,  6, 3'd5, 24'h654321, 6'h3F, 6'h00, 8'd0};
    vecs[8]  = '{7'b0100100, 6'b111100, 10, 0, 1,  6, 3'd0, 24'h654321, 6'h3F, 6'h00, 8'd1};
    vecs[9]  = '{7'b1010101, 6'b110111, 10, 0, 1,  6, 3'd0, 24'h654321, 6'h3F, 6'h00, 8'd2};
    vecs[10] = '{7'h7F,      6'b111011, 10, 1, 0,  6, 3'd2, 24'h654321, 6'h3F, 6'h04, 8'd2};
    vecs[11] = '{7'h7F,      6'b111111, 10, 0, 0, -1, 3'd0, 24'h654321, 6'h3F, 6'h04, 8'd2};

    rst_N = 1'b0; seg_in = 7'h7F; dig_sel_N = 6'h3F;
    tick(); tick();
    check("reset.update", 32'(update), 32'd0);
    check("reset.err", 32'(err), 32'd0);
    check("reset.update_idx", 32'(update_idx), 32'd0);
    check_regs("reset", 24'h0, 6'h00, 6'h3F, 8'd0);
    rst_N = 1'b1;

    for (int v = 0; v < 12; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      hold(vecs[v].seg, vecs[v].sel, vecs[v].cyc);
      check({tag, ".n_upd"}, 32'(n_upd), 32'(vecs[v].n_upd));
      check({tag, ".n_err"}, 32'(n_err), 32'(vecs[v].n_err));
      check({tag, ".first"}, 32'(first), 32'(vecs[v].first));
      check({tag, ".both"}, 32'(both), 32'd0);
      if (vecs[v].n_upd > 0) check({tag, ".idx"}, 32'(idx_s), 32'(vecs[v].idx));
      check_regs(tag, vecs[v].dig, vecs[v].vld, vecs[v].blk, vecs[v].ecnt);
    end

    // Glitch: '9' on digit 4 for only 3 cycles, then a stable '8'.
    hold(7'b0010000, 6'b101111, 3);
    check("glitch.n_upd", 32'(n_upd + n_err), 32'd0);
    hold(7'b0000000, 6'b101111, 10);
    check("after_glitch.n_upd", 32'(n_upd), 32'd1);
    check("after_glitch.first", 32'(first), 32'd6);
    check("after_glitch.idx", 32'(idx_s), 32'd4);
    check("after_glitch.digits", 32'(digits), 32'h684321);

    // Error counter saturation.
    tot_err = 0;
    for (int i = 0; i < 300; i++) begin
      hold(7'b0100100, (i % 2 == 0) ? 6'b111100 : 6'b111010, 6);
      tot_err += n_err;
    end
    check("sat.tot_err", 32'(tot_err), 32'd300);
    check("sat.err_count", 32'(err_count), 32'd255);
    check("sat.digits", 32'(digits), 32'h684321);

    // Async reset in the middle of a pending count, between clock edges.
    hold(7'b1000000, 6'b011111, 4);
    check("pre_rst.n_upd", 32'(n_upd), 32'd0);
    #2 rst_N = 1'b0;
    #1;
    check("async_rst.update", 32'(update), 32'd0);
    check("async_rst.err", 32'(err), 32'd0);
    check_regs("async_rst", 24'h0, 6'h00, 6'h3F, 8'd0);
    tick(); tick();
    rst_N = 1'b1;
    hold(7'b1111000, 6'b111101, 8);
    check("post_rst.n_upd", 32'(n_upd), 32'd1);
    check("post_rst.first", 32'(first), 32'd6);
    check("post_rst.idx", 32'(idx_s), 32'd1);
    check_regs("post_rst", 24'h000070, 6'h02, 6'h3D, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
